clkdiv_ctrl: RTL and testbench

//  Runtime-programmable, glitch-safe clock-divider controller. Generates a

---
 rtl/clkdiv_ctrl_if.sv | 24 ++
 rtl/clkdiv_ctrl.sv | 117 +++++++++++
 tb/tb_clkdiv_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clkdiv_ctrl_if.sv
// Divisor configuration port: valid/ready offer of a new half-period,
// with a one-cycle error pulse for rejected (zero) divisors.
interface clkdiv_ctrl_if #(
  parameter int unsigned WIDTH = 21
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clkdiv_ctrl.sv
// Runtime-programmable glitch-safe clock divider: divisor changes take effect
// only on a full-period (1->0) boundary, and stopping never truncates a high phase.
module clkdiv_ctrl #(
  parameter int unsigned WIDTH       = 21,
  parameter int unsigned DEFAULT_DIV = 1350000
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  clkdiv_ctrl_if.slave      cfg,
  output logic              clk_out,
  output logic              tick,
  output logic [WIDTH-1:0]  active_div,
  output logic              busy
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] pend_div;
  logic             pending;
  logic             at_term;

  assign at_term = (counter == (active_div - ONE));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      counter       <= '0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      cfg.cfg_err   <= 1'b0;
      cfg.cfg_ready <= 1'b1;
      pending       <= 1'b0;
      pend_div      <= '0;
      active_div    <= DEF_DIV;
      busy          <= 1'b0;
    end else begin
      tick        <= 1'b0;
      cfg.cfg_err <= 1'b0;

      // cfg_ready is only high while nothing is pending, so capture and
      // apply can never land on the same edge.
      if (cfg.cfg_valid && cfg.cfg_ready) begin
        if (cfg.cfg_div == '0) begin
          cfg.cfg_err <= 1'b1;
        end else begin
          pend_div      <= cfg.cfg_div;
          pending       <= 1'b1;
          cfg.cfg_ready <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          counter <= '0;
          clk_out <= 1'b0;
          if (pending) begin
            active_div    <= pend_div;
            pending       <= 1'b0;
            cfg.cfg_ready <= 1'b1;
          end
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN, STOP: begin
          if (state == RUN && !en && !clk_out) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else if (at_term) begin
            counter <= '0;
            clk_out <= ~clk_out;
            if (!clk_out) begin
              tick <= 1'b1;
            end else begin
              // Falling edge closes the period: the only safe point to switch divisor.
              if (pending) begin
                active_div    <= pend_div;
                pending       <= 1'b0;
                cfg.cfg_ready <= 1'b1;
              end
              if (en) begin
                state <= RUN;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end else begin
            counter <= counter + ONE;
            state   <= en ? RUN : STOP;
          end
        end

        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          counter <= '0;
          clk_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed scenarios plus random traffic,
// compared each cycle against a period-position reference model.
module tb_clkdiv_ctrl;

  localparam int unsigned W = 8;

  logic         clk_in;
  logic         rst;
  logic         en;
  logic         clk_out;
  logic         tick;
  logic [W-1:0] active_div;
  logic         busy;

  clkdiv_ctrl_if #(.WIDTH(W)) cfg_bus ();

  clkdiv_ctrl #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .cfg        (cfg_bus.slave),
    .clk_out    (clk_out),
    .tick       (tick),
    .active_div (active_div),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position n within the current output period (0..2D-1).
  // Output is high for positions D..2D-1; period boundary when n reaches 2D.
  bit m_run;
  int n;
  int m_d;
  bit m_pend;
  int m_pdiv;
  bit m_tick;
  bit m_err;

  logic [W+4:0] dut_vec;
  assign dut_vec = {clk_out, tick, busy, cfg_bus.cfg_ready, cfg_bus.cfg_err, active_div};

  function automatic logic [W+4:0] mdl_vec();
    logic m_clk;
    m_clk = m_run && (n >= m_d);
    return {m_clk, m_tick, m_run, !m_pend, m_err, W'(m_d)};
  endfunction

  task automatic model_reset();
    m_run = 0; n = 0; m_d = 4; m_pend = 0; m_pdiv = 0; m_tick = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit hs;
    if (rst) begin
      model_reset();
      return;
    end
    hs = cfg_bus.cfg_valid && !m_pend;
    m_tick = 0;
    m_err  = 0;
    if (!m_run) begin
      if (m_pend) begin m_d = m_pdiv; m_pend = 0; end
      if (en) begin m_run = 1; n = 0; end
    end else if (!en && n < m_d) begin
      m_run = 0; n = 0;
    end else begin
      n++;
      if (n == m_d) m_tick = 1;
      else if (n == 2 * m_d) begin
        n = 0;
        if (m_pend) begin m_d = m_pdiv; m_pend = 0; end
        if (!en) m_run = 0;
      end
    end
    if (hs) begin
      if (cfg_bus.cfg_div == '0) m_err = 1;
      else begin m_pdiv = int'(cfg_bus.cfg_div); m_pend = 1; end
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
  endtask

  initial begin
    clk_in = 0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic test_reset();
    rst = 0; en = 0; cfg_bus.cfg_valid = 0; cfg_bus.cfg_div = '0;
    #2 rst = 1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
      end
    end
    rst = 0;
    cycle();
    checks++;
    if (dut_vec !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(4)}) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", dut_vec, {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(4)});
    end
  endtask

  task automatic test_default_run();
    int ticks = 0;
    int first_rise = -1;
    en = 1;
    for (int i = 0; i <= 32; i++) begin
      cycle();
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL default_run cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
      end
      if (i >= 1 && tick) ticks++;
      if (first_rise < 0 && clk_out) first_rise = i;
    end
    checks++;
    if (first_rise != 4) begin
      failures++;
      $display("FAIL first_rise got=%0d exp=4", first_rise);
    end
    checks++;
    if (ticks != 4) begin
      failures++;
      $display("FAIL tick_count_d4 got=%0d exp=4", ticks);
    end
  endtask

  task automatic test_reconfig();
    int guard = 0;
    while (!clk_out && guard < 20) begin
      cycle(); guard++;
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL reconfig_wait got=%h exp=%h", dut_vec, mdl_vec());
      end
    end
    checks++;
    if (!clk_out) begin
      failures++;
      $display("FAIL reconfig_high_timeout got=%b exp=1", clk_out);
    end
    cycle();
    cfg_bus.cfg_valid = 1; cfg_bus.cfg_div = W'(2);
    cycle();
    cfg_bus.cfg_valid = 0;
    checks++;
    if (cfg_bus.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL reconfig_ready_low got=%b exp=0", cfg_bus.cfg_ready);
    end
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL reconfig cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
      end
    end
    checks++;
    if (active_div !== W'(2)) begin
      failures++;
      $display("FAIL reconfig_applied got=%0d exp=2", active_div);
    end
  endtask

  task automatic test_cfg_err();
    int errs = 0;
    cfg_bus.cfg_valid = 1; cfg_bus.cfg_div = '0;
    cycle();
    cfg_bus.cfg_valid = 0;
    if (cfg_bus.cfg_err) errs++;
    checks++;
    if (dut_vec !== mdl_vec()) begin
      failures++;
      $display("FAIL cfg_err_edge got=%h exp=%h", dut_vec, mdl_vec());
    end
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (cfg_bus.cfg_err) errs++;
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL cfg_err cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
      end
    end
    checks++;
    if (errs != 1) begin
      failures++;
      $display("FAIL cfg_err_width got=%0d exp=1", errs);
    end
  endtask

  task automatic test_en_drop();
    int guard = 0;
    cfg_bus.cfg_valid = 1; cfg_bus.cfg_div = W'(4);
    cycle();
    cfg_bus.cfg_valid = 0;
    // wait for divisor 4 to take effect and for a fresh rising edge
    while (!(tick && active_div == W'(4)) && guard < 40) begin
      cycle(); guard++;
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL en_drop_wait got=%h exp=%h", dut_vec, mdl_vec());
      end
    end
    cycle();
    en = 0;
    guard = 0;
    while (busy && guard < 20) begin
      cycle(); guard++;
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL en_drop_high cyc=%0d got=%h exp=%h", guard, dut_vec, mdl_vec());
      end
    end
    checks++;
    if (guard != 3 || clk_out !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_high_len got=%0d/%b exp=3/0", guard, clk_out);
    end
    en = 1;
    cycle(); cycle();
    en = 0;
    cycle();
    checks++;
    if (dut_vec !== mdl_vec() || busy !== 1'b0 || clk_out !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_low got=%h exp=%h", dut_vec, mdl_vec());
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1;
    while (!clk_out && guard < 20) begin
      cycle(); guard++;
    end
    #2 rst = 1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== mdl_vec()) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", dut_vec, mdl_vec());
    end
    en = 0;
    cycle();
    rst = 0;
  endtask

  task automatic test_div1();
    int ticks = 0;
    cfg_bus.cfg_valid = 1; cfg_bus.cfg_div = W'(1);
    cycle();
    cfg_bus.cfg_valid = 0;
    cycle();
    en = 1;
    for (int i = 0; i <= 8; i++) begin
      cycle();
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        $display("FAIL div1 cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
      end
      if (i >= 1 && tick) ticks++;
    end
    checks++;
    if (ticks != 4) begin
      failures++;
      $display("FAIL div1_ticks got=%0d exp=4", ticks);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      cfg_bus.cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_bus.cfg_div   = W'($urandom_range(0, 5));
      cycle();
      checks++;
      if (dut_vec !== mdl_vec()) begin
        failures++;
        if (bad < 10) $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, mdl_vec());
        bad++;
      end
    end
    cfg_bus.cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_reconfig();
    test_cfg_err();
    test_en_drop();
    test_async_reset();
    test_div1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
